// File: rtl/muldiv_sequencer_if.sv
// Handshake/result bundle between the control FSM (master) and muldiv_sequencer (slave).
interface muldiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             hi_we;
  logic             lo_we;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi_out, lo_out, hi_we, lo_we, div_by_zero
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi_out, lo_out, hi_we, lo_we, div_by_zero
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply/divide with HI/LO write strobes; one shared adder.
// Optional MULDIV_DIV0_TRAP_EN: divide by zero finishes in one edge with no HI/LO writes.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      count;
  logic               is_div, is_signed, sign_a, sign_b, b_zero, trapped;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               dbz_q;

  logic               in_signed, in_sa, in_sb, in_div0, trap_take;
  logic [WIDTH-1:0]   mag_a, mag_b;

  always_comb begin
    in_signed = ~bus.op[1];
    in_sa     = in_signed & bus.a[WIDTH-1];
    in_sb     = in_signed & bus.b[WIDTH-1];
    mag_a     = in_sa ? ('0 - bus.a) : bus.a;
    mag_b     = in_sb ? ('0 - bus.b) : bus.b;
    in_div0   = bus.op[0] & (bus.b == '0);
  end

`ifdef MULDIV_DIV0_TRAP_EN
  assign trap_take = in_div0;
`else
  assign trap_take = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = trap_take ? DONE : RUN;
      RUN:     if (count == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  // Shared adder: add for multiply, trial subtract (x + ~d + 1) for divide.
  logic [WIDTH:0]   add_x, add_y, rem_sh;
  logic             add_cin;
  logic [WIDTH+1:0] add_sum;

  always_comb begin
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    if (is_div) begin
      add_x   = rem_sh;
      add_y   = ~{1'b0, opnd};
      add_cin = 1'b1;
    end else begin
      add_x   = {1'b0, acc[2*WIDTH-1:WIDTH]};
      add_y   = {1'b0, opnd};
      add_cin = 1'b0;
    end
    add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               neg_res;

  // With a zero divisor every trial succeeds, so the remainder ends as |a| and
  // the usual sign fix on it reproduces the raw dividend for HI.
  always_comb begin
    neg_res  = is_signed & (sign_a ^ sign_b);
    prod_fix = neg_res ? ('0 - acc) : acc;
    quo_fix  = neg_res ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    if (b_zero) quo_fix = '1;
    rem_fix  = sign_a ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      b_zero    <= 1'b0;
      trapped   <= 1'b0;
      opnd      <= '0;
      acc       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else if (!bus.flush) begin
      unique case (state)
        IDLE: if (bus.start) begin
          is_div    <= bus.op[0];
          is_signed <= in_signed;
          sign_a    <= in_sa;
          sign_b    <= in_sb;
          b_zero    <= in_div0;
          trapped   <= trap_take;
          dbz_q     <= trap_take;
          count     <= CW'(WIDTH);
          opnd      <= mag_b;
          acc       <= {{WIDTH{1'b0}}, mag_a};
        end
        RUN: begin
          count <= count - CW'(1);
          if (is_div) begin
            if (add_sum[WIDTH+1]) acc <= {add_sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else                  acc <= {acc[2*WIDTH-2:0], 1'b0};
          end else begin
            if (acc[0]) acc <= {add_sum[WIDTH:0], acc[WIDTH-1:1]};
            else        acc <= {1'b0, acc[2*WIDTH-1:1]};
          end
        end
        FIX: begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          if (b_zero) dbz_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy        = (state != IDLE);
    bus.done        = (state == DONE);
    bus.hi_we       = bus.done & ~trapped;
    bus.lo_we       = bus.done & ~trapped;
    bus.hi_out      = hi_q;
    bus.lo_out      = lo_q;
    bus.div_by_zero = dbz_q;
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (WIDTH=32).
module tb_muldiv_sequencer;
  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();
  muldiv_sequencer #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Issue one op and wait (bounded) for done; returns done cycle (-1 on timeout).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit busy_ok);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = ~op; bus.a = ~a; bus.b = ~b;
    lat = -1; busy_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) begin lat = c; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.hi_we, bus.lo_we, bus.div_by_zero, bus.hi_out, bus.lo_out} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b we=%b%b dbz=%b hi=%h lo=%h, expected all zero",
               bus.busy, bus.done, bus.hi_we, bus.lo_we, bus.div_by_zero, bus.hi_out, bus.lo_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_mult;
    int lat; bit bok;
    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, lat, bok);
    checks++; if (lat !== 34) begin errors++; $display("FAIL mult_latency: got %0d expected 34", lat); end
    checks++; if (!bok) begin errors++; $display("FAIL mult_busy: busy low before done, expected high cycles 1-34"); end
    checks++; if ({bus.hi_we, bus.lo_we, bus.div_by_zero} !== 3'b110) begin
      errors++; $display("FAIL mult_strobes: got %b expected 110", {bus.hi_we, bus.lo_we, bus.div_by_zero}); end
    checks++; if ({bus.hi_out, bus.lo_out} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      errors++; $display("FAIL mult_neg: got %h_%h expected ffffffff_ffffffeb", bus.hi_out, bus.lo_out); end
    @(negedge clk);
    checks++; if ({bus.busy, bus.done, bus.hi_we} !== 3'b000) begin
      errors++; $display("FAIL mult_after_done: got busy/done/we=%b expected 000", {bus.busy, bus.done, bus.hi_we}); end
  endtask

  task automatic test_mult_corner;
    int lat; bit bok;
    run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bok);
    checks++; if ({bus.hi_out, bus.lo_out} !== 64'hFFFF_FFFE_0000_0001 || lat !== 34) begin
      errors++; $display("FAIL multu_max: got %h_%h lat %0d expected fffffffe_00000001 lat 34", bus.hi_out, bus.lo_out, lat); end
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bok);
    checks++; if ({bus.hi_out, bus.lo_out} !== 64'h0000_0000_0000_0001) begin
      errors++; $display("FAIL mult_m1xm1: got %h_%h expected 00000000_00000001", bus.hi_out, bus.lo_out); end
    run_op(2'b00, 32'h8000_0000, 32'd2, lat, bok);
    checks++; if ({bus.hi_out, bus.lo_out} !== 64'hFFFF_FFFF_0000_0000) begin
      errors++; $display("FAIL mult_minint: got %h_%h expected ffffffff_00000000", bus.hi_out, bus.lo_out); end
  endtask

  task automatic test_div;
    int lat; bit bok;
    run_op(2'b01, 32'hFFFF_FFF9, 32'd2, lat, bok);
    checks++; if ({bus.hi_out, bus.lo_out} !== 64'hFFFF_FFFF_FFFF_FFFD || lat !== 34) begin
      errors++; $display("FAIL div_neg: got %h_%h lat %0d expected ffffffff_fffffffd lat 34", bus.hi_out, bus.lo_out, lat); end
    checks++; if ({bus.hi_we, bus.lo_we, bus.div_by_zero} !== 3'b110) begin
      errors++; $display("FAIL div_strobes: got %b expected 110", {bus.hi_we, bus.lo_we, bus.div_by_zero}); end
    run_op(2'b11, 32'd100, 32'd7, lat, bok);
    checks++; if ({bus.hi_out, bus.lo_out} !== {32'd2, 32'd14}) begin
      errors++; $display("FAIL divu_100_7: got %h_%h expected 00000002_0000000e", bus.hi_out, bus.lo_out); end
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, lat, bok);
    checks++; if ({bus.hi_out, bus.lo_out, bus.div_by_zero} !== {64'h0000_0000_8000_0000, 1'b0}) begin
      errors++; $display("FAIL div_overflow: got %h_%h dbz %b expected 00000000_80000000 dbz 0",
                         bus.hi_out, bus.lo_out, bus.div_by_zero); end
  endtask

  task automatic test_div_zero;
    int lat; bit bok;
    run_op(2'b01, 32'hFFFF_FF00, 32'd0, lat, bok);
`ifdef MULDIV_DIV0_TRAP_EN
    checks++; if (lat !== 1 || !bok) begin errors++; $display("FAIL div0_trap_latency: got %0d busy_ok %b expected 1 and 1", lat, bok); end
    checks++; if ({bus.hi_we, bus.lo_we, bus.div_by_zero} !== 3'b001) begin
      errors++; $display("FAIL div0_trap_strobes: got %b expected 001", {bus.hi_we, bus.lo_we, bus.div_by_zero}); end
    checks++; if ({bus.hi_out, bus.lo_out} !== 64'h0000_0000_8000_0000) begin
      errors++; $display("FAIL div0_trap_hold: got %h_%h expected 00000000_80000000", bus.hi_out, bus.lo_out); end
`else
    checks++; if (lat !== 34) begin errors++; $display("FAIL div0_latency: got %0d expected 34", lat); end
    checks++; if ({bus.hi_we, bus.lo_we, bus.div_by_zero} !== 3'b111) begin
      errors++; $display("FAIL div0_strobes: got %b expected 111", {bus.hi_we, bus.lo_we, bus.div_by_zero}); end
    checks++; if ({bus.hi_out, bus.lo_out} !== 64'hFFFF_FF00_FFFF_FFFF) begin
      errors++; $display("FAIL div0_result: got %h_%h expected ffffff00_ffffffff", bus.hi_out, bus.lo_out); end
`endif
    @(negedge clk);
    checks++; if ({bus.busy, bus.div_by_zero} !== 2'b01) begin
      errors++; $display("FAIL div0_sticky: got busy/dbz=%b expected 01", {bus.busy, bus.div_by_zero}); end
  endtask

  task automatic test_back_to_back;
    int lat; bit bok;
    run_op(2'b11, 32'd100, 32'd7, lat, bok);
    checks++; if ({bus.hi_out, bus.lo_out, bus.div_by_zero, bus.hi_we} !== {32'd2, 32'd14, 1'b0, 1'b1} || lat !== 34) begin
      errors++; $display("FAIL b2b_flag_clear: got %h_%h dbz %b we %b lat %0d expected 00000002_0000000e dbz 0 we 1 lat 34",
                         bus.hi_out, bus.lo_out, bus.div_by_zero, bus.hi_we, lat); end
  endtask

  task automatic test_ignore_start;
    int lat = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd1000; bus.b = 32'd3000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd5; bus.b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 11; c <= 45; c++) begin
      if (bus.done) begin lat = c; break; end
      @(negedge clk);
    end
    checks++; if ({bus.hi_out, bus.lo_out} !== 64'h0000_0000_002D_C6C0 || lat !== 34) begin
      errors++; $display("FAIL ignore_start: got %h_%h lat %0d expected 00000000_002dc6c0 lat 34", bus.hi_out, bus.lo_out, lat); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_no_queue: busy %b expected 0", bus.busy); end
  endtask

  task automatic test_flush;
    bit saw_done = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd7; bus.b = 32'hFFFF_FFFD;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_idle: busy %b expected 0", bus.busy); end
    for (int c = 0; c < 20; c++) begin
      if (bus.done || bus.hi_we || bus.lo_we) saw_done = 1'b1;
      @(negedge clk);
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL flush_no_done: saw done/strobe %b expected 0", saw_done); end
    checks++; if ({bus.hi_out, bus.lo_out} !== 64'h0000_0000_002D_C6C0) begin
      errors++; $display("FAIL flush_hold: got %h_%h expected 00000000_002dc6c0", bus.hi_out, bus.lo_out); end
  endtask

  task automatic test_reset_mid;
    int lat; bit bok;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd256; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.hi_we, bus.lo_we, bus.div_by_zero, bus.hi_out, bus.lo_out} !== '0) begin
      errors++;
      $display("FAIL reset_async: got busy=%b done=%b we=%b%b dbz=%b hi=%h lo=%h, expected all zero",
               bus.busy, bus.done, bus.hi_we, bus.lo_we, bus.div_by_zero, bus.hi_out, bus.lo_out);
    end
    @(negedge clk);
    reset = 1'b0;
    run_op(2'b11, 32'd9, 32'd3, lat, bok);
    checks++; if ({bus.hi_out, bus.lo_out} !== {32'd0, 32'd3} || lat !== 34) begin
      errors++; $display("FAIL reset_recover: got %h_%h lat %0d expected 00000000_00000003 lat 34", bus.hi_out, bus.lo_out, lat); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_mult_corner;
    test_div;
    test_div_zero;
    test_back_to_back;
    test_ignore_start;
    test_flush;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
